// File: rtl/cpu_int_seq_if.sv
// cpu_int_seq_if: vector-fetch bus plus the vector handoff to the decoder.
// master = sequencer side, slave = memory/decoder side.
interface cpu_int_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int SRC_WIDTH  = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_en;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] din;
  logic                  vec_valid;
  logic [ADDR_WIDTH-1:0] vec_pc;
  logic [1:0]            int_type;
  logic [SRC_WIDTH-1:0]  irq_src;
  logic                  vec_ack;

  modport master (
    output addr, rd_en, vec_valid, vec_pc, int_type, irq_src,
    input  rdy, din, vec_ack
  );

  modport slave (
    input  addr, rd_en, vec_valid, vec_pc, int_type, irq_src,
    output rdy, din, vec_ack
  );
endinterface

// File: rtl/cpu_int_seq.sv
// 6502 reset/NMI/BRK/IRQ sequencer; CPU_INT_VECTOR_TABLE_EN selects per-channel IRQ vectors.
// Accept edge -> vec_valid on the 3rd clock with rdy high; rdy low stalls the fetch, vec_valid holds until vec_ack.
module cpu_int_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int IRQ_CHANNELS = 4,
  parameter int SRC_WIDTH    = 2,
  parameter logic [ADDR_WIDTH-1:0] NMI_VEC   = 16'hFFFA,
  parameter logic [ADDR_WIDTH-1:0] RESET_VEC = 16'hFFFC,
`ifdef CPU_INT_VECTOR_TABLE_EN
  parameter logic [ADDR_WIDTH-1:0] IRQ_TABLE_BASE = 16'hFFE0,
`endif
  parameter logic [ADDR_WIDTH-1:0] IRQ_VEC   = 16'hFFFE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [IRQ_CHANNELS-1:0] irq_n,
  input  logic                    nmi_n,
  input  logic                    i_flag,
  input  logic                    brk_req,
  input  logic                    sync,
  output logic                    busy,
  cpu_int_seq_if.master           bus
);

  typedef enum logic [2:0] {S_RST_WAIT, S_IDLE, S_FETCH_LO, S_FETCH_HI, S_DONE} state_t;

  localparam logic [1:0] T_RESET = 2'b00;
  localparam logic [1:0] T_NMI   = 2'b01;
  localparam logic [1:0] T_IRQ   = 2'b10;
  localparam logic [1:0] T_BRK   = 2'b11;

  state_t                state, state_nxt;
  logic                  nmi_q, nmi_pend, nmi_edge, take_nmi;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt, pc_r, pc_nxt, irq_vec_addr;
  logic                  rd_en_r, rd_en_nxt, vld_r, vld_nxt, busy_r, busy_nxt;
  logic [1:0]            type_r, type_nxt;
  logic [SRC_WIDTH-1:0]  src_r, src_nxt, irq_idx;
  logic                  irq_any;

  assign nmi_edge = nmi_q & ~nmi_n;

  // Scan from the top so the lowest-index active channel is the last write.
  always_comb begin
    irq_any = 1'b0;
    irq_idx = '0;
    for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
      if (!irq_n[i]) begin
        irq_any = 1'b1;
        irq_idx = SRC_WIDTH'(i);
      end
    end
  end

`ifdef CPU_INT_VECTOR_TABLE_EN
  assign irq_vec_addr = IRQ_TABLE_BASE + (ADDR_WIDTH'(irq_idx) << 1);
`else
  assign irq_vec_addr = IRQ_VEC;
`endif

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_r;
    rd_en_nxt = rd_en_r;
    vld_nxt   = vld_r;
    busy_nxt  = busy_r;
    pc_nxt    = pc_r;
    type_nxt  = type_r;
    src_nxt   = src_r;
    take_nmi  = 1'b0;
    case (state)
      S_RST_WAIT: begin
        state_nxt = S_FETCH_LO;
        addr_nxt  = RESET_VEC;
        rd_en_nxt = 1'b1;
        busy_nxt  = 1'b1;
        type_nxt  = T_RESET;
        src_nxt   = '0;
      end
      S_IDLE: begin
        if (sync && (nmi_pend || brk_req || (irq_any && !i_flag))) begin
          state_nxt = S_FETCH_LO;
          rd_en_nxt = 1'b1;
          busy_nxt  = 1'b1;
          src_nxt   = '0;
          if (nmi_pend) begin
            take_nmi = 1'b1;
            addr_nxt = NMI_VEC;
            type_nxt = T_NMI;
          end else if (brk_req) begin
            addr_nxt = IRQ_VEC;
            type_nxt = T_BRK;
          end else begin
            addr_nxt = irq_vec_addr;
            type_nxt = T_IRQ;
            src_nxt  = irq_idx;
          end
        end
      end
      S_FETCH_LO: begin
        if (bus.rdy) begin
          pc_nxt[DATA_WIDTH-1:0] = bus.din;
          addr_nxt  = addr_r + ADDR_WIDTH'(1);
          state_nxt = S_FETCH_HI;
        end
      end
      S_FETCH_HI: begin
        if (bus.rdy) begin
          pc_nxt[ADDR_WIDTH-1:DATA_WIDTH] = bus.din;
          rd_en_nxt = 1'b0;
          vld_nxt   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.vec_ack) begin
          vld_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_RST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RST_WAIT;
      nmi_q    <= 1'b1;
      nmi_pend <= 1'b0;
      addr_r   <= '0;
      rd_en_r  <= 1'b0;
      vld_r    <= 1'b0;
      busy_r   <= 1'b1;
      pc_r     <= '0;
      type_r   <= T_RESET;
      src_r    <= '0;
    end else begin
      state    <= state_nxt;
      nmi_q    <= nmi_n;
      // An edge landing mid-sequence survives until the next acceptance.
      nmi_pend <= (nmi_pend & ~take_nmi) | nmi_edge;
      addr_r   <= addr_nxt;
      rd_en_r  <= rd_en_nxt;
      vld_r    <= vld_nxt;
      busy_r   <= busy_nxt;
      pc_r     <= pc_nxt;
      type_r   <= type_nxt;
      src_r    <= src_nxt;
    end
  end

  assign bus.addr      = addr_r;
  assign bus.rd_en     = rd_en_r;
  assign bus.vec_valid = vld_r;
  assign bus.vec_pc    = pc_r;
  assign bus.int_type  = type_r;
  assign bus.irq_src   = src_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_cpu_int_seq.sv
// Scoreboard bench for cpu_int_seq: expected vectors are queued at stimulus time and popped when vec_valid rises.
module tb_cpu_int_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] irq_n = 4'b1111;
  logic       nmi_n = 1'b1;
  logic       i_flag = 1'b0;
  logic       brk_req = 1'b0;
  logic       sync = 1'b0;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [1:0]  t;
    logic [15:0] a;
    logic [15:0] pc;
    logic [1:0]  src;
  } exp_t;
  exp_t sb_q[$];

  cpu_int_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .SRC_WIDTH(2)) bus();

  assign bus.din = mem[bus.addr];

  cpu_int_seq #(
    .DATA_WIDTH(8), .ADDR_WIDTH(16), .IRQ_CHANNELS(4), .SRC_WIDTH(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .irq_n(irq_n), .nmi_n(nmi_n), .i_flag(i_flag),
    .brk_req(brk_req), .sync(sync), .busy(busy), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] irq_addr(input int ch);
`ifdef CPU_INT_VECTOR_TABLE_EN
    return 16'hFFE0 + 16'(2 * ch);
`else
    return 16'hFFFE + 16'(ch * 0);
`endif
  endfunction

  task automatic push_exp(input logic [1:0] t, input logic [15:0] a, input logic [1:0] src);
    exp_t e;
    logic [15:0] a1;
    a1 = a + 16'd1;
    e.t = t; e.a = a; e.src = src;
    e.pc = {mem[a1], mem[a]};
    sb_q.push_back(e);
  endtask

  // Monitor: track the fetch addresses, score each vector as it appears.
  logic        prev_rd = 1'b0, prev_vld = 1'b0;
  logic [15:0] first_a = '0, hi_a = '0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.rd_en && !prev_rd) first_a = bus.addr;
    if (bus.rd_en) hi_a = bus.addr;
    if (bus.vec_valid && !prev_vld) begin
      if (sb_q.size() == 0) begin
        check("unexpected_vec", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        n_done++;
        check("int_type", 32'(bus.int_type), 32'(e.t));
        check("vec_pc", 32'(bus.vec_pc), 32'(e.pc));
        check("irq_src", 32'(bus.irq_src), 32'(e.src));
        check("addr_lo", 32'(first_a), 32'(e.a));
        check("addr_hi", 32'(hi_a), 32'(e.a + 16'd1));
      end
    end
    prev_rd  = bus.rd_en;
    prev_vld = bus.vec_valid;
  end

  // Caller drives the request before calling; edge 1 is the acceptance edge.
  task automatic wait_vld(input string tag, input int exp_lat);
    int n;
    n = 1;
    @(negedge clk);
    sync = 1'b0;
    brk_req = 1'b0;
    while (!bus.vec_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk);
    check({tag, "_hold_vld"}, 32'(bus.vec_valid), 32'd1);
    check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    bus.vec_ack = 1'b1;
    @(negedge clk);
    bus.vec_ack = 1'b0;
    check({tag, "_ack_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack_vld"}, 32'(bus.vec_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(bus.addr), 32'd0);
    check({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_vld"}, 32'(bus.vec_valid), 32'd0);
    check({tag, "_pc"}, 32'(bus.vec_pc), 32'd0);
    check({tag, "_type"}, 32'(bus.int_type), 32'd0);
    check({tag, "_src"}, 32'(bus.irq_src), 32'd0);
  endtask

  task automatic idle_sync(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      sync = 1'b1;
      @(negedge clk);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    end
    sync = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'hEF; mem[16'hFFFF] = 8'hBE;
    bus.rdy = 1'b1;
    bus.vec_ack = 1'b0;

    // Reset state and reset-vector fetch
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    push_exp(2'b00, 16'hFFFC, 2'd0);
    reset_n = 1'b1;
    wait_vld("rst_fetch", 3);
    do_ack("rst_fetch");

    // NMI beats a pending IRQ; IRQ follows at the next sync
    nmi_n = 1'b0;
    irq_n = 4'b1010;
    repeat (2) @(negedge clk);
    check("no_sync_busy", 32'(busy), 32'd0);
    push_exp(2'b01, 16'hFFFA, 2'd0);
    push_exp(2'b10, irq_addr(0), 2'd0);
    sync = 1'b1;
    wait_vld("nmi", 3);
    do_ack("nmi");
    sync = 1'b1;
    wait_vld("irq0", 3);
    do_ack("irq0");
    nmi_n = 1'b1;

    // Masked IRQ is never accepted; BRK ignores the mask
    i_flag = 1'b1;
    irq_n = 4'b1011;
    idle_sync("masked", 4);
    push_exp(2'b11, 16'hFFFE, 2'd0);
    sync = 1'b1;
    brk_req = 1'b1;
    wait_vld("brk", 3);
    do_ack("brk");
    i_flag = 1'b0;

    // Stall three cycles in the high-byte fetch; IRQ drops mid-fetch
    irq_n = 4'b1101;
    push_exp(2'b10, irq_addr(1), 2'd1);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    irq_n = 4'b1111;
    @(negedge clk);
    n = 2;
    bus.rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n++;
      check("stall_addr", 32'(bus.addr), 32'(irq_addr(1) + 16'd1));
      check("stall_rd_en", 32'(bus.rd_en), 32'd1);
      check("stall_vld", 32'(bus.vec_valid), 32'd0);
    end
    bus.rdy = 1'b1;
    while (!bus.vec_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stall_latency", 32'(n), 32'd6);
    do_ack("stall");

    // Reset during the low-byte fetch of an IRQ
    irq_n = 4'b1110;
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("abort_rd_en", 32'(bus.rd_en), 32'd1);
    check("abort_addr", 32'(bus.addr), 32'(irq_addr(0)));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    irq_n = 4'b1111;
    push_exp(2'b00, 16'hFFFC, 2'd0);
    reset_n = 1'b1;
    wait_vld("rst2", 3);
    do_ack("rst2");
    idle_sync("post_rst", 3);

    // Highest channel only
    irq_n = 4'b0111;
    push_exp(2'b10, irq_addr(3), 2'd3);
    sync = 1'b1;
    wait_vld("irq3", 3);
    do_ack("irq3");
    irq_n = 4'b1111;

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("vec_count", 32'(n_done), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_int_seq.md
Name: cpu_int_seq

Overview:
- Parametrised interrupt and reset sequencer for the 6502 core.
- Arbitrates reset, NMI, BRK and multi-channel IRQ requests at instruction boundaries.
- Fetches the two-byte vector over the data bus, then hands the new PC to the decoder via a valid/ack handshake.
- Sits between the external interrupt pins, the status register I flag, the decoder and the address/data bus.

Parameters:
- DATA_WIDTH, 8: data bus width; vector is two bytes, low then high.
- ADDR_WIDTH, 16: address bus width; must equal 2*DATA_WIDTH.
- IRQ_CHANNELS, 4: number of independent active-low IRQ inputs, at least 1.
- SRC_WIDTH, 2: width of irq_src; must be at least clog2(IRQ_CHANNELS), minimum 1.
- NMI_VEC, 16'hFFFA: NMI vector low-byte address.
- RESET_VEC, 16'hFFFC: reset vector low-byte address.
- IRQ_VEC, 16'hFFFE: IRQ/BRK vector low-byte address.
- IRQ_TABLE_BASE, 16'hFFE0: base of the per-channel vector table; used only with the optional feature.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- irq_n  in  IRQ_CHANNELS  level-sensitive IRQ requests, active low
- nmi_n  in  1  NMI request, falling-edge sensitive
- i_flag  in  1  status I (interrupt disable) bit
- brk_req  in  1  one-cycle pulse from the decoder when BRK executes
- sync  in  1  high on the instruction-boundary (opcode fetch) cycle
- rdy  in  1  bus ready; low stalls the vector fetch
- din  in  DATA_WIDTH  data bus read value
- addr  out  ADDR_WIDTH  vector fetch address
- rd_en  out  1  high while a vector byte read is in progress
- busy  out  1  high from request acceptance until vec_ack
- vec_valid  out  1  vector ready
- vec_pc  out  ADDR_WIDTH  fetched vector as {high byte, low byte}
- int_type  out  2  00 reset, 01 NMI, 10 IRQ, 11 BRK
- irq_src  out  SRC_WIDTH  winning IRQ channel; 0 for non-IRQ types
- vec_ack  in  1  decoder has consumed vec_pc

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = S_RST_WAIT; nmi_pend = 0; nmi_n edge history register = 1.
  - addr, rd_en, vec_valid, vec_pc, int_type, irq_src all 0; busy = 1.
  - First rising clk with reset_n high: go to S_FETCH_LO with int_type = 00 and address = RESET_VEC.
- States: S_RST_WAIT, S_IDLE, S_FETCH_LO, S_FETCH_HI, S_DONE. All outputs are registered.
- NMI detection:
  - nmi_pend sets on a registered 1->0 transition of nmi_n, in any state except reset.
  - nmi_pend clears on the cycle an NMI is accepted.
  - An edge arriving during an in-flight sequence stays pending and is served next.
- Acceptance (only in S_IDLE with sync = 1), priority NMI > BRK > IRQ:
  - NMI if nmi_pend.
  - Else BRK if brk_req; taken regardless of i_flag.
  - Else IRQ if any irq_n bit is low and i_flag = 0; lowest-index active channel wins and is latched into irq_src.
  - On acceptance: busy = 1 and go to S_FETCH_LO.
- S_FETCH_LO:
  - addr = vector address; rd_en = 1.
  - On a cycle with rdy = 1: latch din into vec_pc low byte, addr + 1, go to S_FETCH_HI.
  - rdy = 0 holds addr and rd_en unchanged.
- S_FETCH_HI:
  - On a cycle with rdy = 1: latch din into the high byte, rd_en = 0, vec_valid = 1, go to S_DONE.
- S_DONE:
  - Hold vec_valid, vec_pc, int_type and irq_src stable until vec_ack = 1.
  - On vec_ack: vec_valid = 0, busy = 0, go to S_IDLE next cycle.
  - vec_ack outside S_DONE is ignored.
- Latency with rdy held high: acceptance edge -> vec_valid high after 3 clocks.
- IRQ de-asserted mid-fetch: the fetch completes regardless; level is sampled only at acceptance.
- brk_req while busy is ignored; the decoder does not issue one in that state.
- reset_n low mid-sequence: abort immediately, all outputs back to reset values, restart with a reset-vector fetch.
- Address arithmetic is modulo 2^ADDR_WIDTH; a vector at the top address wraps to 0 for the high byte.

Optional Feature:
- Macro: CPU_INT_VECTOR_TABLE_EN.
- Defined: an IRQ from channel n fetches from IRQ_TABLE_BASE + 2*n. BRK, NMI and reset vectors are unchanged.
- Undefined: all IRQ channels use IRQ_VEC; irq_src is still reported.

Test Plan:
- Reset vector fetch:
  - Stimulus: release reset_n; memory model FFFC=34, FFFD=12; rdy = 1.
  - Required: rd_en with addr FFFC then FFFD; vec_valid with vec_pc = 1234 and int_type = 00 three clocks after the first edge; busy clears on vec_ack.
- Priority:
  - Stimulus: nmi_n falls, irq_n = 4'b1010, i_flag = 0; sync pulse in S_IDLE.
  - Required: NMI served first from FFFA. At the next sync, IRQ served from FFFE with irq_src = 0.
- Masking and BRK:
  - Stimulus: i_flag = 1 with irq_n[2] low; sync pulses.
  - Required: no acceptance and busy stays 0.
  - Stimulus: brk_req with sync.
  - Required: int_type = 11, fetch from FFFE.
- Stall:
  - Stimulus: rdy low for 3 cycles during S_FETCH_HI.
  - Required: addr stays FFFF, rd_en stays 1, vec_valid delayed by exactly 3 cycles, vec_pc correct.
- Reset mid-operation:
  - Stimulus: reset_n pulsed low during S_FETCH_LO of an IRQ sequence.
  - Required: outputs zero immediately; after release, a reset-vector fetch occurs and the earlier IRQ is not resumed.
- With CPU_INT_VECTOR_TABLE_EN:
  - Stimulus: irq_n = 4'b0111.
  - Required: channel 3 wins; fetch from FFE6/FFE7; irq_src = 3.
